// File: rtl/scroll_display_buffer.sv
// scroll_display_buffer: circular character store feeding a static or scrolling 7-segment window
module scroll_display_buffer #(
  parameter int CHAR_W = 5,
  parameter int DEPTH = 16,
  parameter int DIGITS = 8,
  parameter logic [CHAR_W-1:0] BLANK_CODE = {1'b1, {(CHAR_W-1){1'b0}}}
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               wr_en,
  input  logic [CHAR_W-1:0]                  wr_data,
  input  logic                               mode,
  input  logic                               step,
  input  logic                               char_req,
  output logic [CHAR_W-1:0]                  char_out,
  output logic                               char_valid,
  output logic [($clog2(DIGITS)|1)-1:0]      char_dig,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic                               full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = $clog2(DIGITS) | 1;
  localparam int W = $clog2(DEPTH+DIGITS);
  localparam logic [W:0] DIG_L = (W+1)'(DIGITS);
  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, wr_addr, rd_addr;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0] off_q, off_d;
  logic [DW-1:0] dig_q, dig_d, char_dig_q, char_dig_d;
  logic mode_q, valid_q, valid_d, we, mc;
  logic [CHAR_W-1:0] char_out_q, char_out_d, rd_char;
  logic [W:0] len, s_sum, s_idx, p_sum, p, idx;
  logic s_blank, sc_blank, blank;
  // Both window positions are computed one extra bit wide so nothing wraps.
  always_comb begin
    len = (W+1)'(count_q) + DIG_L;
    s_sum = (W+1)'(dig_q) + (W+1)'(count_q);
    s_blank = s_sum < DIG_L;
    s_idx = s_sum - DIG_L;
    p_sum = {1'b0, off_q} + (W+1)'(dig_q);
    p = (p_sum >= len) ? p_sum - len : p_sum;
    sc_blank = p >= (W+1)'(count_q);
    idx = mode_q ? p : s_idx;
    blank = mode_q ? sc_blank : s_blank;
    rd_addr = head_q + PW'(idx);
    rd_char = blank ? BLANK_CODE : mem_q[rd_addr];
    wr_addr = head_q + PW'(count_q);
    full = count_q == CW'(DEPTH);
    mc = mode != mode_q;
  end
  always_comb begin
    count_d = count_q;
    head_d = head_q;
    off_d = off_q;
    dig_d = dig_q;
    char_out_d = char_out_q;
    char_dig_d = char_dig_q;
    valid_d = 1'b0;
    we = 1'b0;
    if (clear) begin
      count_d = '0;
      off_d = '0;
      dig_d = '0;
    end else begin
      we = wr_en;
      if (wr_en) begin
        head_d = full ? head_q + 1'b1 : head_q;
        count_d = full ? count_q : count_q + 1'b1;
      end
      if (step && mode_q)
        off_d = ({1'b0, off_q} == len - 1'b1) ? '0 : off_q + 1'b1;
      if (char_req) begin
        char_out_d = rd_char;
        char_dig_d = dig_q;
        valid_d = 1'b1;
        dig_d = (dig_q == DW'(DIGITS-1)) ? '0 : dig_q + 1'b1;
      end
      // A mode change restarts the frame; the same-cycle request still used mode_q.
      if (mc) begin
        off_d = '0;
        dig_d = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      count_q <= '0;
      off_q <= '0;
      dig_q <= '0;
      mode_q <= 1'b0;
      char_out_q <= BLANK_CODE;
      char_dig_q <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q <= head_d;
      count_q <= count_d;
      off_q <= off_d;
      dig_q <= dig_d;
      mode_q <= mode;
      char_out_q <= char_out_d;
      char_dig_q <= char_dig_d;
      valid_q <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      mem_q <= '{default: '0};
    else if (we)
      mem_q[wr_addr] <= wr_data;
  end
  assign char_out = char_out_q;
  assign char_valid = valid_q;
  assign char_dig = char_dig_q;
  assign count = count_q;
endmodule

// File: tb/tb_scroll_display_buffer.sv
// tb_scroll_display_buffer: table-driven directed check of static/scroll windows, overwrite, clear and reset
module tb_scroll_display_buffer;
  localparam logic [4:0] B = 5'h10;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, wr_en = 1'b0, mode = 1'b0, step = 1'b0, char_req = 1'b0;
  logic [4:0] wr_data = '0;
  logic [4:0] char_out;
  logic char_valid, full;
  logic [2:0] char_dig;
  logic [4:0] count;
  int checks = 0, errors = 0;
  typedef struct {
    bit clr, wr, md, stp, req, ck, ev;
    logic [4:0] d, ec, en;
    logic [2:0] ed;
  } vec_t;
  vec_t tbl[$];
  logic [4:0] ex [8];
  scroll_display_buffer dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .mode(mode),
    .step(step), .char_req(char_req), .char_out(char_out), .char_valid(char_valid),
    .char_dig(char_dig), .count(count), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input bit clr, wr, md, stp, req, ck, input logic [4:0] d, ec,
                              input logic [2:0] ed, input logic [4:0] en);
    vec_t v;
    v.clr = clr; v.wr = wr; v.md = md; v.stp = stp; v.req = req; v.ck = ck;
    v.ev = req & ~clr; v.d = d; v.ec = ec; v.ed = ed; v.en = en;
    tbl.push_back(v);
  endfunction
  function automatic void add_frame(input bit md, input logic [4:0] cnt);
    for (int d = 0; d < 8; d++) add(0, 0, md, 0, 1, 1, '0, ex[d], 3'(d), cnt);
  endfunction
  task automatic run(input vec_t v, input int k);
    clear = v.clr; wr_en = v.wr; wr_data = v.d; mode = v.md; step = v.stp; char_req = v.req;
    @(posedge clk); #1;
    chk($sformatf("valid[%0d]", k), 32'(char_valid), 32'(v.ev));
    chk($sformatf("full_count[%0d]", k), 32'({full, count}), 32'({v.en == 5'd16, v.en}));
    if (v.ck) begin
      chk($sformatf("char_out[%0d]", k), 32'(char_out), 32'(v.ec));
      chk($sformatf("char_dig[%0d]", k), 32'(char_dig), 32'(v.ed));
    end
    clear = 0; wr_en = 0; step = 0; char_req = 0;
  endtask
  task automatic req1(input bit md, input logic [4:0] ec, input logic [2:0] ed, input logic [4:0] en, input int k);
    vec_t v;
    v.clr = 0; v.wr = 0; v.md = md; v.stp = 0; v.req = 1; v.ck = 1; v.ev = 1;
    v.d = '0; v.ec = ec; v.ed = ed; v.en = en;
    run(v, k);
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_char_out"}, 32'(char_out), 32'(B));
    chk({tag, "_valid"}, 32'(char_valid), 32'd0);
    chk({tag, "_dig"}, 32'(char_dig), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
  endtask
  initial begin
    // reset frame: all blank
    ex = '{B, B, B, B, B, B, B, B};
    add_frame(0, 0);
    // three chars right-aligned, then outputs hold without a request
    for (int i = 1; i <= 3; i++) add(0, 1, 0, 0, 0, 0, 5'(i), '0, '0, 5'(i));
    ex = '{B, B, B, B, B, 5'd1, 5'd2, 5'd3};
    add_frame(0, 3);
    add(0, 0, 0, 0, 0, 1, '0, 5'd3, 3'd7, 5'd3);
    // overfill: 18 writes keep the newest 16 (2..17); window shows 10..17
    add(1, 0, 0, 0, 0, 0, '0, '0, '0, 5'd0);
    for (int i = 0; i < 18; i++) add(0, 1, 0, 0, 0, 0, 5'(i), '0, '0, (i < 16) ? 5'(i + 1) : 5'd16);
    for (int d = 0; d < 8; d++) ex[d] = 5'(10 + d);
    add_frame(0, 16);
    // scroll: L=11, ten steps -> off=10, one more wraps to 0
    add(1, 0, 0, 0, 0, 0, '0, '0, '0, 5'd0);
    for (int i = 1; i <= 3; i++) add(0, 1, 0, 0, 0, 0, 5'(i), '0, '0, 5'(i));
    add(0, 0, 1, 0, 0, 0, '0, '0, '0, 5'd3);
    for (int i = 0; i < 10; i++) add(0, 0, 1, 1, 0, 0, '0, '0, '0, 5'd3);
    ex = '{B, 5'd1, 5'd2, 5'd3, B, B, B, B};
    add_frame(1, 3);
    add(0, 0, 1, 1, 0, 0, '0, '0, '0, 5'd3);
    ex = '{5'd1, 5'd2, 5'd3, B, B, B, B, B};
    add_frame(1, 3);
    // clear beats write; a read alongside a write sees pre-write contents
    add(0, 0, 0, 0, 0, 0, '0, '0, '0, 5'd3);
    add(1, 1, 0, 0, 0, 0, 5'd9, '0, '0, 5'd0);
    ex = '{B, B, B, B, B, B, B, B};
    add_frame(0, 0);
    add(0, 1, 0, 0, 0, 0, 5'd6, '0, '0, 5'd1);
    for (int d = 0; d < 7; d++) add(0, 0, 0, 0, 1, 1, '0, B, 3'(d), 5'd1);
    add(0, 1, 0, 0, 1, 1, 5'd8, 5'd6, 3'd7, 5'd2);
    ex = '{B, B, B, B, B, B, 5'd6, 5'd8};
    add_frame(0, 2);
    repeat (2) @(posedge clk);
    #1 chk_reset("reset");
    rst = 0;
    foreach (tbl[k]) run(tbl[k], k);
    // mode toggle mid-frame, then reset between requests 3 and 4
    req1(0, B, 3'd0, 5'd2, 900);
    req1(1, B, 3'd1, 5'd2, 901);
    req1(1, 5'd6, 3'd0, 5'd2, 902);
    rst = 1; mode = 0;
    @(posedge clk); #1;
    chk_reset("midrst");
    rst = 0;
    req1(0, B, 3'd0, 5'd0, 903);
    req1(0, B, 3'd1, 5'd0, 904);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
